// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg: register file geometry, hazard FSM states, decoder opcode constants
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_BR_WAIT = 2'd1,
    HZ_FLUSH   = 2'd2
  } hz_state_t;

  // Opcodes seen by the stage decoders that generate the dec_* controls
  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_add  = 4'h1;
  localparam logic [3:0] c_op_sub  = 4'h2;
  localparam logic [3:0] c_op_cmp  = 4'h3;
  localparam logic [3:0] c_op_ld   = 4'h4;
  localparam logic [3:0] c_op_st   = 4'h5;
  localparam logic [3:0] c_op_jmp  = 4'h8;
  localparam logic [3:0] c_op_jz   = 4'h9;
  localparam logic [3:0] c_op_jn   = 4'hA;
  localparam logic [3:0] c_op_call = 4'hB;

  localparam logic [REG_AW-1:0] c_link_reg = 3'd7;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if: decode/writeback status in, stage enables out
// Revision: 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW   = 3,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
);

  logic              dec_valid;
  logic [REG_AW-1:0] dec_rs_a;
  logic              dec_use_a;
  logic [REG_AW-1:0] dec_rs_b;
  logic              dec_use_b;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_rd_we;
  logic              dec_sets_flags;
  logic              dec_is_ctrl;
  logic              dec_uses_flags;

  logic              wb_valid;
  logic              wb_rf_we;
  logic [REG_AW-1:0] wb_rf_addr;
  logic              wb_sets_flags;
  logic              wb_redirect;

  logic                fetch_en;
  logic                rf_read_en;
  logic                issue;
  logic                flush;
  logic [NUM_REGS-1:0] sb_busy;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    output dec_valid, dec_rs_a, dec_use_a, dec_rs_b, dec_use_b,
           dec_rd, dec_rd_we, dec_sets_flags, dec_is_ctrl, dec_uses_flags,
           wb_valid, wb_rf_we, wb_rf_addr, wb_sets_flags, wb_redirect,
    input  fetch_en, rf_read_en, issue, flush, sb_busy, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rs_a, dec_use_a, dec_rs_b, dec_use_b,
           dec_rd, dec_rd_we, dec_sets_flags, dec_is_ctrl, dec_uses_flags,
           wb_valid, wb_rf_we, wb_rf_addr, wb_sets_flags, wb_redirect,
    output fetch_en, rf_read_en, issue, flush, sb_busy, stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_scoreboard: per-register write-pending bits, set wins over clear
// Revision: 1.0
// ============================================================================
module reg_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                set_en,
  input  wire logic [REG_AW-1:0]   set_addr,
  input  wire logic                clr_en,
  input  wire logic [REG_AW-1:0]   clr_addr,
  input  wire logic [REG_AW-1:0]   lookup_a,
  input  wire logic [REG_AW-1:0]   lookup_b,
  output logic                     busy_a,
  output logic                     busy_b,
  output logic [NUM_REGS-1:0]      busy
);

  logic [NUM_REGS-1:0] r_busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    always_ff @(posedge clk) begin
      if (reset) begin
        r_busy[i] <= 1'b0;
      end else if (set_en && (set_addr == REG_AW'(i))) begin
        r_busy[i] <= 1'b1;
      end else if (clr_en && (clr_addr == REG_AW'(i))) begin
        r_busy[i] <= 1'b0;
      end
    end
  end

  // Lookups see registered state only: a retiring write still reads busy
  assign busy_a = r_busy[lookup_a];
  assign busy_b = r_busy[lookup_b];
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl: RAW/WAW/flag stall, branch freeze/flush, stall counter
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3,
  parameter int CNT_W    = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pipe_hazard_ctrl_if.slave bus
);

  import cpu_pkg::*;

  hz_state_t           r_state;
  logic                r_flag_busy;
  logic [CNT_W-1:0]    r_stall_cycles;

  logic                w_busy_a;
  logic                w_busy_b;
  logic [NUM_REGS-1:0] w_sb_busy;
  logic                w_run;
  logic                w_hazard;
  logic                w_issue;
  logic                w_stall;
  logic                w_fetch_en;
  logic                w_sb_set;
  logic                w_sb_clr;

  assign w_sb_set = w_issue & bus.dec_rd_we;
  assign w_sb_clr = bus.wb_valid & bus.wb_rf_we;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (w_sb_set),
    .set_addr (bus.dec_rd),
    .clr_en   (w_sb_clr),
    .clr_addr (bus.wb_rf_addr),
    .lookup_a (bus.dec_rs_a),
    .lookup_b (bus.dec_rs_b),
    .busy_a   (w_busy_a),
    .busy_b   (w_busy_b),
    .busy     (w_sb_busy)
  );

  assign w_run    = (r_state == HZ_RUN);
  assign w_hazard = (bus.dec_use_a      & w_busy_a)
                  | (bus.dec_use_b      & w_busy_b)
                  | (bus.dec_rd_we      & w_sb_busy[bus.dec_rd])
                  | (bus.dec_uses_flags & r_flag_busy);
  assign w_issue  = w_run & bus.dec_valid & ~w_hazard;
  assign w_stall  = w_run & bus.dec_valid &  w_hazard;

  // Fetch freezes behind an issuing control instruction; FLUSH refetches
  assign w_fetch_en = (w_run & ~w_stall & ~(w_issue & bus.dec_is_ctrl))
                    | (r_state == HZ_FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HZ_RUN;
    end else begin
      case (r_state)
        HZ_RUN: begin
          if (w_issue && bus.dec_is_ctrl) begin
            r_state <= HZ_BR_WAIT;
          end
        end
        HZ_BR_WAIT: begin
          if (bus.wb_valid) begin
            r_state <= bus.wb_redirect ? HZ_FLUSH : HZ_RUN;
          end
        end
        HZ_FLUSH: r_state <= HZ_RUN;
        default:  r_state <= HZ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag_busy <= 1'b0;
    end else if (w_issue && bus.dec_sets_flags) begin
      r_flag_busy <= 1'b1;
    end else if (bus.wb_valid && bus.wb_sets_flags) begin
      r_flag_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.fetch_en     = w_fetch_en;
  assign bus.rf_read_en   = w_fetch_en;
  assign bus.issue        = w_issue;
  assign bus.flush        = (r_state == HZ_FLUSH);
  assign bus.sb_busy      = w_sb_busy;
  assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
